// File: rtl/stream_capture_buf_if.sv
// Valid/ready stream carrying signed T-bit words from the upstream layer
// into the capture buffer.
interface stream_capture_buf_if #(
  parameter int T = 16
);
  logic signed [T-1:0] s_data_in;
  logic                s_valid;
  logic                s_ready;

  modport master (output s_data_in, output s_valid, input s_ready);
  modport slave  (input s_data_in, input s_valid, output s_ready);
endinterface

// File: rtl/stream_capture_buf.sv
// Captures one frame of NUMVALS signed words into a RAM, tracking a running
// 32-bit checksum and signed maximum; a 1-cycle read port drains the frame.
module stream_capture_buf #(
  parameter int T       = 16,
  parameter int NUMVALS = 4992,
  parameter int AW      = $clog2(NUMVALS)
) (
  input  logic                clk,
  input  logic                reset,
  stream_capture_buf_if.slave s,
  input  logic                clear,
  input  logic                rd_en,
  input  logic [AW-1:0]       rd_addr,
  output logic signed [T-1:0] rd_data,
  output logic                rd_valid,
  output logic [AW:0]         count,
  output logic                done,
  output logic [31:0]         checksum,
  output logic signed [T-1:0] max_val
);

  typedef enum logic [0:0] {CAPTURE = 1'b0, FULL = 1'b1} state_t;

  localparam logic signed [T-1:0] MOST_NEG = {1'b1, {(T-1){1'b0}}};
  localparam logic [AW:0]         LAST_CNT = (AW+1)'(NUMVALS - 1);

  state_t              state_r;
  state_t              state_nxt_s;
  logic                s_ready_s;
  logic                xfer_s;
  logic                wr_en_s;
  logic [AW:0]         count_r;
  logic                done_r;
  logic [31:0]         checksum_r;
  logic signed [T-1:0] max_r;
  logic signed [T-1:0] rd_data_r;
  logic                rd_valid_r;
  logic signed [T-1:0] mem_r [NUMVALS];

  function automatic logic [31:0] sext32(input logic signed [T-1:0] d);
    return {{(32-T){d[T-1]}}, d};
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= CAPTURE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and handshake; ready depends on state only, held low in reset.
  always_comb begin
    state_nxt_s = state_r;
    s_ready_s   = 1'b0;
    xfer_s      = 1'b0;
    case (state_r)
      CAPTURE: begin
        s_ready_s = ~reset;
        xfer_s    = s.s_valid & s_ready_s;
        if (xfer_s && (count_r == LAST_CNT)) begin
          state_nxt_s = FULL;
        end else begin
          state_nxt_s = CAPTURE;
        end
      end
      FULL: begin
        state_nxt_s = FULL;
      end
      default: begin
        state_nxt_s = CAPTURE;
      end
    endcase
    if (clear) begin
      state_nxt_s = CAPTURE;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // A word coinciding with clear is dropped, so it must not reach the RAM.
  assign wr_en_s = xfer_s & ~clear;

  // Frame statistics: count, done flag, checksum and signed maximum.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_r    <= {(AW+1){1'b0}};
      done_r     <= 1'b0;
      checksum_r <= 32'd0;
      max_r      <= MOST_NEG;
    end else if (xfer_s) begin
      count_r    <= count_r + {{AW{1'b0}}, 1'b1};
      checksum_r <= checksum_r + sext32(s.s_data_in);
      if (s.s_data_in > max_r) begin
        max_r <= s.s_data_in;
      end
      if (count_r == LAST_CNT) begin
        done_r <= 1'b1;
      end
    end
  end

  // Capture RAM write port; contents survive reset and clear.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[count_r[AW-1:0]] <= s.s_data_in;
    end
  end

  // Registered read port; same-address write in the same cycle returns old data.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= {T{1'b0}};
    end else begin
      rd_valid_r <= rd_en;
      if (rd_en) begin
        rd_data_r <= mem_r[rd_addr];
      end
    end
  end

  assign s.s_ready = s_ready_s;
  assign count     = count_r;
  assign done      = done_r;
  assign checksum  = checksum_r;
  assign max_val   = max_r;
  assign rd_data   = rd_data_r;
  assign rd_valid  = rd_valid_r;

endmodule

// File: tb/tb_stream_capture_buf.sv
// Directed bench for stream_capture_buf: a bench-side frame model predicts
// status outputs, and a queue holds expected read data until rd_valid.
module tb_stream_capture_buf;
  localparam int T       = 16;
  localparam int NUMVALS = 4992;
  localparam int AW      = $clog2(NUMVALS);

  logic                clk = 1'b0;
  logic                reset;
  logic                clear;
  logic                rd_en;
  logic [AW-1:0]       rd_addr;
  logic signed [T-1:0] rd_data;
  logic                rd_valid;
  logic [AW:0]         count;
  logic                done;
  logic [31:0]         checksum;
  logic signed [T-1:0] max_val;

  stream_capture_buf_if #(.T(T)) sif ();

  stream_capture_buf #(.T(T), .NUMVALS(NUMVALS)) dut (
    .clk(clk), .reset(reset), .s(sif), .clear(clear),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .count(count), .done(done), .checksum(checksum), .max_val(max_val)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [T-1:0] m_mem [NUMVALS];
  int           m_count;
  logic [31:0]  m_sum;
  logic [T-1:0] m_max;
  bit           m_full;
  logic [T-1:0] rd_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_count = 0;
    m_sum   = 32'd0;
    m_max   = 16'h8000;
    m_full  = 1'b0;
  endtask

  task automatic check_status(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(m_count));
    chk({tag, ".done"}, 32'(done), 32'(m_full));
    chk({tag, ".checksum"}, checksum, m_sum);
    chk({tag, ".max_val"}, {16'h0, max_val}, {16'h0, m_max});
  endtask

  // One clock cycle of stream stimulus, entered and left at negedge.
  task automatic step(input logic v, input logic [T-1:0] d, input logic clr, input string tag);
    sif.s_valid   = v;
    sif.s_data_in = v ? d : 'x;
    clear         = clr;
    #1;
    chk({tag, ".s_ready"}, 32'(sif.s_ready), 32'(!m_full));
    @(posedge clk);
    if (clr) begin
      model_clear();
    end else if (v && !m_full) begin
      m_mem[m_count] = d;
      m_count++;
      m_sum += {{16{d[T-1]}}, d};
      if ($signed(d) > $signed(m_max)) m_max = d;
      if (m_count == NUMVALS) m_full = 1'b1;
    end
    @(negedge clk);
    sif.s_valid = 1'b0;
    clear       = 1'b0;
    check_status(tag);
  endtask

  task automatic do_reset(input string tag);
    reset       = 1'b1;
    sif.s_valid = 1'b1;
    #1;
    chk({tag, ".s_ready_in_reset"}, 32'(sif.s_ready), 32'd0);
    @(posedge clk);
    model_clear();
    @(negedge clk);
    reset       = 1'b0;
    sif.s_valid = 1'b0;
    check_status(tag);
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'd0);
  endtask

  // Keeps rd_en high across consecutive calls, giving back-to-back reads.
  task automatic issue_read(input int addr, input string tag);
    rd_en   = 1'b1;
    rd_addr = AW'(addr);
    rd_q.push_back(m_mem[addr]);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'd1);
    if (rd_q.size() > 0) chk({tag, ".rd_data"}, {16'h0, rd_data}, {16'h0, rd_q.pop_front()});
  endtask

  task automatic read_idle(input string tag);
    rd_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".rd_valid_low"}, 32'(rd_valid), 32'd0);
  endtask

  initial begin
    logic [T-1:0] pat [4];
    logic [T-1:0] held;
    int k;
    pat[0] = 16'hFFFD; pat[1] = 16'h0007; pat[2] = 16'h8000; pat[3] = 16'h7FFF;
    reset = 1'b0; clear = 1'b0; rd_en = 1'b0; rd_addr = '0;
    sif.s_valid = 1'b0; sif.s_data_in = '0;
    model_clear();
    @(negedge clk);
    do_reset("reset");
    chk("reset.rd_data", {16'h0, rd_data}, 32'd0);

    // Test 1: continuous ramp fills the frame in NUMVALS cycles.
    for (int i = 0; i < NUMVALS; i++) step(1'b1, T'(i), 1'b0, "ramp");
    chk("ramp.count_const", 32'(count), 32'd4992);
    chk("ramp.checksum_const", checksum, 32'd12457536);
    chk("ramp.max_const", {16'h0, max_val}, 32'h0000137F);

    // Test 3: FULL ignores further words.
    for (int i = 0; i < 20; i++) step(1'b1, 16'h7FFF, 1'b0, "full_hold");

    // Test 6: back-to-back reads after done.
    issue_read(0, "rd0");
    issue_read(1, "rd1");
    issue_read(NUMVALS - 1, "rdlast");
    read_idle("rd_idle");

    // Test 2: random valid with corner values.
    step(1'b0, 16'h0000, 1'b1, "clear2");
    k = 0;
    while (!m_full && k < 30000) begin
      step(1'($urandom_range(0, 1)), (k < 8) ? pat[k % 4] : T'($urandom), 1'b0, "rand");
      k++;
    end
    chk("rand.reached_full", 32'(m_full), 32'd1);
    for (int i = 0; i < 5; i++) step(1'b1, 16'h1111, 1'b0, "rand_full");
    for (int i = 0; i < 4; i++) issue_read(i, "rand_rd");
    issue_read(NUMVALS - 1, "rand_rdlast");
    read_idle("rand_idle");

    // Test 4: all-negative frame.
    step(1'b0, 16'h0000, 1'b1, "clear4");
    for (int i = 0; i < NUMVALS; i++) step(1'b1, 16'hFFFB, 1'b0, "neg");
    chk("neg.max_const", {16'h0, max_val}, 32'h0000FFFB);
    chk("neg.checksum_const", checksum, 32'hFFFF9E80);

    // Test 5: clear colliding with a transfer at count=100.
    step(1'b0, 16'h0000, 1'b1, "clear5");
    for (int i = 0; i < 100; i++) step(1'b1, T'(1000 + i), 1'b0, "pre_clr");
    step(1'b1, 16'h1234, 1'b1, "clr_xfer");
    chk("clr_xfer.count0", 32'(count), 32'd0);
    step(1'b1, 16'h0AAA, 1'b0, "post_clr");
    step(1'b1, 16'h0BBB, 1'b0, "post_clr");
    issue_read(0, "post_rd0");
    issue_read(1, "post_rd1");
    issue_read(100, "dropped_rd");
    read_idle("post_idle");

    // Mid-frame reset leaves RAM intact.
    held = m_mem[0];
    do_reset("mid_reset");
    issue_read(0, "retain_rd");
    chk("retain.value", {16'h0, rd_data}, {16'h0, held});
    read_idle("retain_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
